// File: rtl/contador_8bits.sv
// 8-bit up/down counter driven by divider tick edges, with load, wrap/saturate and terminal pulse.
// Build option: define CONTADOR_BCD_EN for two-digit BCD counting (00..99); RESET_VAL must then be valid BCD.
module contador_8bits #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iEnable,
    input  logic       iUp,
    input  logic       iWrap,
    input  logic       iLoad,
    input  logic [7:0] ivLoadVal,
    input  logic [1:0] ivRateSel,
    input  logic       iClkDiv2,
    input  logic       iClkDiv4,
    input  logic       iClkDiv8,
    input  logic       iClkDiv16,
    output logic [7:0] ovCount,
    output logic       oTerminal,
    output logic       oRunning
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] divVec;
    logic [3:0] divHist;
    logic [3:0] divEdge;
    logic       tick;

    // Each divider input keeps its own history so switching ivRateSel cannot fabricate an edge.
    assign divVec  = {iClkDiv16, iClkDiv8, iClkDiv4, iClkDiv2};
    assign divEdge = divVec & ~divHist;
    assign tick    = divEdge[ivRateSel];

    logic [7:0] maxVal;
    logic [7:0] incVal;
    logic [7:0] decVal;
    logic [7:0] loadVal;
    logic       atMax;
    logic       atMin;

`ifdef CONTADOR_BCD_EN
    always_comb begin
        maxVal  = 8'h99;
        incVal  = ovCount;
        decVal  = ovCount;
        loadVal = ivLoadVal;
        if (ovCount[3:0] >= 4'd9) begin
            incVal = {ovCount[7:4] + 4'd1, 4'd0};
        end else begin
            incVal = {ovCount[7:4], ovCount[3:0] + 4'd1};
        end
        if (ovCount[3:0] == 4'd0) begin
            decVal = {ovCount[7:4] - 4'd1, 4'd9};
        end else begin
            decVal = {ovCount[7:4], ovCount[3:0] - 4'd1};
        end
        // Out-of-range digits are clamped so the count always stays valid BCD.
        if (ivLoadVal[7:4] > 4'd9) loadVal[7:4] = 4'd9;
        if (ivLoadVal[3:0] > 4'd9) loadVal[3:0] = 4'd9;
    end
`else
    always_comb begin
        maxVal  = 8'hFF;
        incVal  = ovCount + 8'd1;
        decVal  = ovCount - 8'd1;
        loadVal = ivLoadVal;
    end
`endif

    assign atMax = (ovCount == maxVal);
    assign atMin = (ovCount == 8'h00);

    // Priority: reset, then load, then tick. Counting needs RUN and iEnable both high.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= STOP;
            ovCount   <= RESET_VAL;
            oTerminal <= 1'b0;
            oRunning  <= 1'b0;
            divHist   <= 4'b0000;
        end else begin
            divHist   <= divVec;
            oTerminal <= 1'b0;
            if (iLoad) begin
                ovCount  <= loadVal;
                state    <= iEnable ? RUN : STOP;
                oRunning <= iEnable;
            end else begin
                case (state)
                    STOP: begin
                        if (iEnable) begin
                            state    <= RUN;
                            oRunning <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!iEnable) begin
                            state    <= STOP;
                            oRunning <= 1'b0;
                        end else if (tick) begin
                            if (iUp) begin
                                if (!atMax) begin
                                    ovCount <= incVal;
                                end else begin
                                    oTerminal <= 1'b1;
                                    if (iWrap) begin
                                        ovCount <= 8'h00;
                                    end else begin
                                        state    <= DONE;
                                        oRunning <= 1'b0;
                                    end
                                end
                            end else begin
                                if (!atMin) begin
                                    ovCount <= decVal;
                                end else begin
                                    oTerminal <= 1'b1;
                                    if (iWrap) begin
                                        ovCount <= maxVal;
                                    end else begin
                                        state    <= DONE;
                                        oRunning <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    DONE: begin
                        oRunning <= 1'b0;
                    end
                    default: begin
                        state    <= STOP;
                        oRunning <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contador_8bits.sv
// Scoreboard bench for contador_8bits: a decimal-value reference model predicts every cycle's outputs.
module tb_contador_8bits;

    localparam logic [7:0] RESET_VAL = 8'h00;
`ifdef CONTADOR_BCD_EN
    localparam bit BCD  = 1'b1;
    localparam int MAXV = 99;
`else
    localparam bit BCD  = 1'b0;
    localparam int MAXV = 255;
`endif

    logic       iClk = 1'b0;
    logic       iReset, iEnable, iUp, iWrap, iLoad;
    logic [7:0] ivLoadVal;
    logic [1:0] ivRateSel;
    logic [3:0] div;
    logic [7:0] ovCount;
    logic       oTerminal, oRunning;

    always #5 iClk = ~iClk;

    contador_8bits #(.RESET_VAL(RESET_VAL)) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iEnable   (iEnable),
        .iUp       (iUp),
        .iWrap     (iWrap),
        .iLoad     (iLoad),
        .ivLoadVal (ivLoadVal),
        .ivRateSel (ivRateSel),
        .iClkDiv2  (div[0]),
        .iClkDiv4  (div[1]),
        .iClkDiv8  (div[2]),
        .iClkDiv16 (div[3]),
        .ovCount   (ovCount),
        .oTerminal (oTerminal),
        .oRunning  (oRunning)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    // Reference model: count held as a plain integer value, encoded only for comparison.
    int       m_val;
    bit       m_run, m_done, m_term;
    bit [3:0] m_prev;

    function automatic int to_int(input logic [7:0] v);
        if (BCD) return int'(v[7:4]) * 10 + int'(v[3:0]);
        return int'(v);
    endfunction

    function automatic logic [7:0] enc(input int v);
        logic [3:0] t, o;
        if (BCD) begin
            t = 4'(v / 10);
            o = 4'(v % 10);
            return {t, o};
        end
        return 8'(v);
    endfunction

    function automatic int load_int(input logic [7:0] v);
        int hi, lo;
        if (!BCD) return int'(v);
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_step();
        bit tk;
        if (iReset) begin
            m_val  = to_int(RESET_VAL);
            m_run  = 0;
            m_done = 0;
            m_term = 0;
            m_prev = 4'b0000;
        end else begin
            tk     = div[ivRateSel] && !m_prev[ivRateSel];
            m_prev = div;
            m_term = 0;
            if (iLoad) begin
                m_val  = load_int(ivLoadVal);
                m_done = 0;
                m_run  = iEnable;
            end else if (m_done) begin
                m_run = 0;
            end else if (m_run && iEnable && tk) begin
                if (iUp && m_val < MAXV) m_val = m_val + 1;
                else if (!iUp && m_val > 0) m_val = m_val - 1;
                else begin
                    m_term = 1;
                    if (iWrap) m_val = iUp ? 0 : MAXV;
                    else begin
                        m_done = 1;
                        m_run  = 0;
                    end
                end
            end else begin
                m_run = iEnable;
            end
        end
    endtask

    // Apply current inputs for one clock: predict, enqueue, then step past the edge.
    task automatic cyc();
        model_step();
        exp_q.push_back({enc(m_val), m_term, m_run});
        @(posedge iClk);
        #2;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got count=%h term=%b run=%b, expected count=%h term=%b run=%b",
                     name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: the counter presents an output every cycle, so pop one expectation per edge.
    always @(posedge iClk) begin
        logic [9:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {ovCount, oTerminal, oRunning}, e);
        end
    end

    task automatic pulse(input int idx);
        div[idx] = 1'b1;
        cyc();
        div[idx] = 1'b0;
        cyc();
    endtask

    initial begin
        iReset = 1; iEnable = 0; iUp = 1; iWrap = 1; iLoad = 0;
        ivLoadVal = 8'h00; ivRateSel = 2'd0; div = 4'b0000;
        cyc();
        cyc();
        check("reset_state", {ovCount, oTerminal, oRunning}, {RESET_VAL, 1'b0, 1'b0});

        // Count up ten Div2 pulses.
        iReset = 0; iEnable = 1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            div[0] = 1'b1;
            cyc();
            check("up_step", {ovCount, oTerminal, oRunning}, {enc(to_int(RESET_VAL) + i + 1), 1'b0, 1'b1});
            div[0] = 1'b0;
            cyc();
        end
        if (!BCD) check("ten_pulses", {ovCount, oTerminal, oRunning}, {8'h0A, 1'b0, 1'b1});

        // Up wrap through the top limit.
        iLoad = 1; ivLoadVal = BCD ? 8'h98 : 8'hFE;
        cyc();
        iLoad = 0;
        pulse(0);
        check("wrap_top_pre", {ovCount, oTerminal, oRunning}, {BCD ? 8'h99 : 8'hFF, 1'b0, 1'b1});
        div[0] = 1'b1;
        cyc();
        check("wrap_top", {ovCount, oTerminal, oRunning}, {8'h00, 1'b1, 1'b1});
        div[0] = 1'b0;
        cyc();
        check("wrap_term_clear", {ovCount, oTerminal, oRunning}, {8'h00, 1'b0, 1'b1});

        // Down saturation into DONE, then recover by load.
        iLoad = 1; ivLoadVal = 8'h01; iUp = 0; iWrap = 0;
        cyc();
        iLoad = 0;
        pulse(0);
        check("down_to_zero", {ovCount, oTerminal, oRunning}, {8'h00, 1'b0, 1'b1});
        div[0] = 1'b1;
        cyc();
        check("sat_bottom", {ovCount, oTerminal, oRunning}, {8'h00, 1'b1, 1'b0});
        div[0] = 1'b0;
        cyc();
        pulse(0);
        check("done_ignores", {ovCount, oTerminal, oRunning}, {8'h00, 1'b0, 1'b0});
        iLoad = 1; ivLoadVal = 8'h05;
        cyc();
        iLoad = 0;
        check("load_exits_done", {ovCount, oTerminal, oRunning}, {8'h05, 1'b0, 1'b1});

        // Held Div16 level counts once; switching select onto a held Div8 gives no count.
        iUp = 1; iWrap = 1; ivRateSel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            div[3] = 1'b1; div[0] = ~div[0];
            cyc();
        end
        div[3] = 1'b0; div[0] = 1'b0;
        cyc();
        check("held_level_once", {ovCount, oTerminal, oRunning}, {8'h06, 1'b0, 1'b1});
        div[2] = 1'b1;
        cyc();
        ivRateSel = 2'd2;
        cyc();
        cyc();
        div[2] = 1'b0;
        cyc();
        check("sel_switch_no_tick", {ovCount, oTerminal, oRunning}, {8'h06, 1'b0, 1'b1});

        // Load beats a coincident tick; reset beats a coincident tick.
        ivRateSel = 2'd0;
        iLoad = 1; ivLoadVal = 8'h40; div[0] = 1'b1;
        cyc();
        iLoad = 0; div[0] = 1'b0;
        check("load_over_tick", {ovCount, oTerminal, oRunning}, {8'h40, 1'b0, 1'b1});
        iReset = 1; div[0] = 1'b1;
        cyc();
        iReset = 0; div[0] = 1'b0;
        check("reset_over_tick", {ovCount, oTerminal, oRunning}, {RESET_VAL, 1'b0, 1'b0});
        cyc();

        if (BCD) begin
            iLoad = 1; ivLoadVal = 8'hAF;
            cyc();
            iLoad = 0;
            check("bcd_load_clamp", {ovCount, oTerminal, oRunning}, {8'h99, 1'b0, 1'b1});
        end

        // Random phase, biased towards loads near the limits.
        for (int i = 0; i < 3000; i++) begin
            int r;
            iReset  = ($urandom_range(0, 99) == 0);
            iLoad   = ($urandom_range(0, 19) == 0);
            r       = $urandom_range(0, 3);
            ivLoadVal = (r == 0) ? 8'hFE : (r == 1) ? 8'h01 : 8'($urandom);
            iEnable = ($urandom_range(0, 7) != 0);
            iUp     = 1'($urandom_range(0, 1));
            iWrap   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ivRateSel = 2'($urandom_range(0, 3));
            div     = 4'($urandom_range(0, 15));
            cyc();
        end

        iReset = 0; iLoad = 0; div = 4'b0000;
        cyc();
        @(posedge iClk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/contador_8bits.md
Name: contador_8bits

Overview:
- 8-bit up/down counter for the counter datapath, located directly downstream of the clock divider.
- Consumes the divider's /2, /4, /8 and /16 tick outputs as count-enable sources. It does not use them as clocks; the whole block runs on iClk.
- Supports synchronous load, direction control, wrap or saturate mode, and a terminal-count pulse for display or chaining logic.

Parameters:
- RESET_VAL, 8'h00, value loaded into ovCount on reset.

Ports:
- iClk  in  1  system clock; all logic on posedge.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  count enable; 0 freezes the count.
- iUp  in  1  direction: 1 = increment, 0 = decrement.
- iWrap  in  1  1 = wrap at limits, 0 = saturate at limits.
- iLoad  in  1  synchronous load strobe.
- ivLoadVal  in  8  value loaded when iLoad=1.
- ivRateSel  in  2  tick source: 0 = Div2, 1 = Div4, 2 = Div8, 3 = Div16.
- iClkDiv2, iClkDiv4, iClkDiv8, iClkDiv16  in  1 each  divider outputs, synchronous to iClk.
- ovCount  out  8  current count.
- oTerminal  out  1  one-cycle pulse on wrap or saturation.
- oRunning  out  1  1 while FSM is in RUN.

Behaviour:
- Reset is synchronous, active-high on iReset, clocked by iClk. On reset:
  - ovCount = RESET_VAL, oTerminal = 0, FSM = STOP, oRunning = 0.
  - All four edge-detect history registers = 0.
- Tick detection:
  - Each divider input has its own history flop; edgeX = iClkDivX & ~histX.
  - tick = the edge selected by ivRateSel.
  - Because history is tracked per input, changing ivRateSel never creates a spurious tick.
  - A level held high for several cycles counts once.
- FSM states: STOP, RUN, DONE.
  - STOP -> RUN when iEnable = 1.
  - RUN -> STOP when iEnable = 0.
  - RUN -> DONE on a saturating limit hit (iWrap = 0).
  - DONE: ticks are ignored. Exits only via iLoad or reset.
  - iLoad in any state -> RUN if iEnable = 1, else STOP.
- Priority per cycle: reset > load > tick.
  - Load: ovCount = ivLoadVal on the next edge. A tick in the same cycle is discarded, and oTerminal = 0.
- Count, in RUN with tick = 1 (ovCount changes on the same iClk edge the tick is sampled; visible 1 cycle after the input rises):
  - Up, ovCount < 8'hFF: +1.
  - Up, ovCount = 8'hFF: iWrap = 1 -> 8'h00; iWrap = 0 -> hold 8'hFF and go to DONE. oTerminal = 1 in both cases.
  - Down, ovCount > 0: -1.
  - Down, ovCount = 8'h00: iWrap = 1 -> 8'hFF; iWrap = 0 -> hold 8'h00 and go to DONE. oTerminal = 1 in both cases.
- oTerminal is registered and high for exactly the cycle in which ovCount shows the post-limit value.
- Ticks are dropped while in STOP or DONE.
- iUp and iWrap are sampled every cycle; a change takes effect at the next tick.
- Reset mid-count overrides everything, including a pending load or tick.

Optional Feature:
- Macro: CONTADOR_BCD_EN.
- Defined: the counter runs as two-digit BCD, ovCount = {tens, ones}, range 8'h00 to 8'h99.
  - Up: ones 9 -> 0 with carry into tens.
  - Down: ones 0 -> 9 with borrow from tens.
  - Limits are 8'h99 and 8'h00, with the same wrap/saturate/oTerminal rules as binary.
  - On load, each nibble greater than 9 is clamped to 9 (e.g. 8'h3C loads 8'h39).
  - RESET_VAL must be valid BCD.
- Undefined: plain 8-bit binary as described in Behaviour.

Test Plan:
- Reset with RESET_VAL = 8'h00, then iEnable = 1, iUp = 1, ivRateSel = 0, Div2 pulsing one cycle in two for 10 pulses -> ovCount = 8'h0A, each step visible one cycle after the pulse, oTerminal never high.
- Load 8'hFE, iUp = 1, iWrap = 1, two ticks -> 8'hFF then 8'h00; oTerminal high for exactly the cycle showing 8'h00.
- Load 8'h01, iUp = 0, iWrap = 0, three ticks -> 8'h00, oTerminal pulse, oRunning drops to 0 (DONE); third tick leaves 8'h00; load 8'h05 -> RUN, ovCount = 8'h05.
- ivRateSel = 3 with Div2 toggling and Div16 high for 3 consecutive cycles -> exactly one increment; switching ivRateSel while Div8 is held high causes no count.
- iLoad = 1 with ivLoadVal = 8'h40 in the same cycle as a tick -> ovCount = 8'h40, no increment; reset asserted during a tick -> ovCount = RESET_VAL, oTerminal = 0.
- With CONTADOR_BCD_EN defined: load 8'h98, two up ticks, iWrap = 1 -> 8'h99 then 8'h00 with oTerminal pulse; load 8'hAF -> 8'h99.
